// File: rtl/writeback_store_queue.sv
// Write-back stage with an in-order store queue.
// Register results commit one cycle after acceptance; stores are buffered
// and retired to the D-cache by a small drain FSM. The queue contents are
// also searched combinationally to forward store data to younger loads.
module writeback_store_queue #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter int          NUM_REGS  = 16,
  parameter logic [12:0] WRITE_TAG = 13'h1000,
  localparam int         RI        = $clog2(NUM_REGS),
  localparam int         CW        = $clog2(DEPTH + 1),
  localparam int         PW        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic                wb_kill,
  input  logic                wb_is_store,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                wb_dest_valid,
  input  logic [RI-1:0]       wb_dest_reg,
  input  logic [DATA_W-1:0]   wb_dest_value,
  output logic                wb_ready,
  output logic                reg_we,
  output logic [RI-1:0]       reg_waddr,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [NUM_REGS-1:0] inuse_clear,
  output logic                mem_reqcyc,
  output logic [ADDR_W-1:0]   mem_req,
  output logic [DATA_W-1:0]   mem_reqdata,
  output logic [12:0]         mem_reqtag,
  input  logic                mem_reqack,
  input  logic                mem_writeack,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hit,
  output logic [DATA_W-1:0]   ld_data,
  output logic [CW-1:0]       sq_count,
  output logic                sq_empty,
  output logic                sq_full,
  output logic                store_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;
  logic                reg_we_q;
  logic [RI-1:0]       reg_waddr_q;
  logic [DATA_W-1:0]   reg_wdata_q;
  logic [NUM_REGS-1:0] inuse_clear_q;
  logic                mem_reqcyc_q;
  logic                store_done_q;
  logic                accept_s;
  logic                enq_s;
  logic                pop_s;
  logic [PW-1:0]       fwd_idx_s;
  logic                fwd_match_s;

  // Occupancy flags come straight from the pre-edge count, so a full queue
  // never accepts in the same cycle that it pops.
  assign sq_full  = (count_q == CW'(DEPTH));
  assign sq_empty = (count_q == {CW{1'b0}});
  assign sq_count = count_q;
  assign wb_ready = !(wb_is_store && sq_full);
  assign accept_s = wb_valid && !wb_kill && wb_ready;
  assign enq_s    = accept_s && wb_is_store;

  assign reg_we      = reg_we_q;
  assign reg_waddr   = reg_waddr_q;
  assign reg_wdata   = reg_wdata_q;
  assign inuse_clear = inuse_clear_q;
  assign store_done  = store_done_q;

  // Request fields are only meaningful while a request is outstanding;
  // otherwise they read as zero.
  assign mem_reqcyc  = mem_reqcyc_q;
  assign mem_req     = mem_reqcyc_q ? addr_q[head_q] : {ADDR_W{1'b0}};
  assign mem_reqdata = mem_reqcyc_q ? data_q[head_q] : {DATA_W{1'b0}};
  assign mem_reqtag  = mem_reqcyc_q ? WRITE_TAG : 13'h0000;

  // Head retires on writeack, either together with reqack or in WAIT.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      S_REQ: begin
        if (mem_reqack && mem_writeack) pop_s = 1'b1;
        else                            pop_s = 1'b0;
      end
      S_WAIT: begin
        if (mem_writeack) pop_s = 1'b1;
        else              pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // Forwarding search, oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit      = 1'b0;
    ld_data     = {DATA_W{1'b0}};
    fwd_idx_s   = {PW{1'b0}};
    fwd_match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s   = head_q + PW'(i);
      fwd_match_s = (CW'(i) < count_q) && (addr_q[fwd_idx_s] == ld_addr);
      ld_hit      = ld_hit | fwd_match_s;
      ld_data     = fwd_match_s ? data_q[fwd_idx_s] : ld_data;
    end
  end

  // Register-file write port and in-use clear, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_we_q      <= 1'b0;
      reg_waddr_q   <= {RI{1'b0}};
      reg_wdata_q   <= {DATA_W{1'b0}};
      inuse_clear_q <= {NUM_REGS{1'b0}};
    end else if (accept_s && wb_dest_valid) begin
      reg_we_q      <= 1'b1;
      reg_waddr_q   <= wb_dest_reg;
      reg_wdata_q   <= wb_dest_value;
      inuse_clear_q <= {{(NUM_REGS-1){1'b0}}, 1'b1} << wb_dest_reg;
    end else begin
      reg_we_q      <= 1'b0;
      reg_waddr_q   <= {RI{1'b0}};
      reg_wdata_q   <= {DATA_W{1'b0}};
      inuse_clear_q <= {NUM_REGS{1'b0}};
    end
  end

  // Entry storage; validity is tracked by the pointers and count, not here.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_q[tail_q] <= wb_addr;
      data_q[tail_q] <= wb_data;
    end else begin
      addr_q[tail_q] <= addr_q[tail_q];
      data_q[tail_q] <= data_q[tail_q];
    end
  end

  // Ring pointers and occupancy count; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (enq_s) tail_q <= tail_q + PW'(1);
      else       tail_q <= tail_q;
      if (pop_s) head_q <= head_q + PW'(1);
      else       head_q <= head_q;
      case ({enq_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Drain FSM: issue the head entry to the cache and wait for completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_reqcyc_q <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      store_done_q <= pop_s;
      case (state_q)
        S_IDLE: begin
          if (!sq_empty) begin
            state_q      <= S_REQ;
            mem_reqcyc_q <= 1'b1;
          end else begin
            state_q      <= S_IDLE;
            mem_reqcyc_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_reqack && mem_writeack) begin
            state_q      <= S_IDLE;
            mem_reqcyc_q <= 1'b0;
          end else if (mem_reqack) begin
            state_q      <= S_WAIT;
            mem_reqcyc_q <= 1'b0;
          end else begin
            state_q      <= S_REQ;
            mem_reqcyc_q <= 1'b1;
          end
        end
        S_WAIT: begin
          mem_reqcyc_q <= 1'b0;
          if (mem_writeack) state_q <= S_IDLE;
          else              state_q <= S_WAIT;
        end
        default: begin
          state_q      <= S_IDLE;
          mem_reqcyc_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
